// File: rtl/ic_service_ctrl.sv
// ic_service_ctrl: vectors the interrupt controller's winner to the CPU, acks on take, tracks service until EOI.
// Define IC_SVC_TIMEOUT_EN to add the request timeout and the sticky timeout_err output.
module ic_service_ctrl #(
  parameter int VEC_W = 16,
  parameter logic [VEC_W-1:0] VEC_BASE = 'h0100,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 'h0004,
  parameter int CNT_W = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             irq_out,
  input  logic [2:0]       irq_id,
  output logic             ack,
  output logic             cpu_irq_req,
  output logic [VEC_W-1:0] cpu_vector,
  input  logic             cpu_irq_taken,
  input  logic             cpu_eoi,
  output logic             busy,
  output logic [2:0]       active_id,
  output logic [CNT_W-1:0] svc_count
`ifdef IC_SVC_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, next;
  logic tmo_fire;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign cpu_irq_req = (state == REQ) && irq_out && (irq_id == active_id);
  assign ack = cpu_irq_req && cpu_irq_taken;
  assign busy = (state == SERVICE);
  assign cpu_vector = VEC_BASE + VEC_W'(active_id) * VEC_STRIDE;
`ifdef IC_SVC_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;
  assign tmo_fire = cpu_irq_req && !cpu_irq_taken && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // tcnt is zero in the first REQ cycle, so the timeout fires on the TIMEOUT_CYCLES-th one
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= (state == REQ) ? tcnt + 1'b1 : '0;
      if (tmo_fire) timeout_err <= 1'b1;
    end
`else
  assign tmo_fire = 1'b0;
`endif
  always_comb begin
    next = (state == IDLE)    ? (irq_out ? REQ : IDLE) :
           (state == REQ)     ? ((!cpu_irq_req || tmo_fire) ? IDLE : cpu_irq_taken ? SERVICE : REQ) :
           (state == SERVICE) ? (cpu_eoi ? IDLE : SERVICE) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      active_id <= '0;
      svc_count <= '0;
    end else begin
      state <= next;
      if (state == IDLE && irq_out) active_id <= irq_id;
      if (state == SERVICE && cpu_eoi && !(&svc_count)) svc_count <= svc_count + 1'b1;
    end
endmodule

// File: doc/ic_service_ctrl.md
Name: ic_service_ctrl

Overview:
- Sits directly downstream of the interrupt controller. It consumes irq_out/irq_id and presents a vectored request to the CPU.
- It generates the single-cycle ack that clears the serviced pending bit.
- It tracks the in-service interrupt until the CPU signals end-of-interrupt (EOI).
- At most one interrupt is in service at a time; there is no nesting.

Parameters:
- VEC_W, 16, width of the CPU vector address.
- VEC_BASE, 16'h0100, vector of IRQ0.
- VEC_STRIDE, 16'h0004, vector spacing between consecutive IRQ ids.
- CNT_W, 16, width of the serviced-interrupt counter.
- TIMEOUT_CYCLES, 64, request timeout in cycles. Used only when IC_SVC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- irq_out  in  1  interrupt pending, from the interrupt controller
- irq_id  in  3  highest-priority pending id, from the interrupt controller
- ack  out  1  acknowledge to the interrupt controller; clears the current highest-priority pending bit
- cpu_irq_req  out  1  interrupt request to the CPU
- cpu_vector  out  VEC_W  vector for active_id
- cpu_irq_taken  in  1  CPU accepts the request; sampled only while cpu_irq_req=1
- cpu_eoi  in  1  CPU end-of-interrupt pulse
- busy  out  1  an interrupt is in service
- active_id  out  3  latched id of the requested or in-service interrupt
- svc_count  out  CNT_W  number of completed services, saturating
- timeout_err  out  1  sticky request-timeout flag. Present only with IC_SVC_TIMEOUT_EN.

Behaviour:
- Reset: clk clock; reset rstn, asynchronous, active-low. On reset:
  - state=IDLE, active_id=0, cpu_vector=VEC_BASE.
  - ack=0, cpu_irq_req=0, busy=0, svc_count=0, timeout_err=0.
  - Reset mid-operation abandons any request or service immediately. Nothing is acked.
- States: IDLE, REQ, SERVICE. Encoding is free.
- IDLE:
  - If irq_out=1, register active_id<=irq_id and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - cpu_irq_req = (state==REQ) && irq_out && (irq_id==active_id). This is combinational.
  - If cpu_irq_req=0 (a higher-priority id arrived, or pending cleared), go to IDLE. IDLE re-latches the new id on the next cycle.
  - If cpu_irq_req && cpu_irq_taken, then ack=1 in that same cycle and the next state is SERVICE.
  - ack = cpu_irq_req && cpu_irq_taken. ack is therefore only ever asserted while irq_id==active_id, which guarantees the controller clears exactly the bit that was vectored.
- SERVICE:
  - busy=1.
  - On cpu_eoi=1: go to IDLE and increment svc_count, saturating at all-ones.
  - New irq_out is ignored until IDLE.
- cpu_eoi outside SERVICE is ignored. cpu_irq_taken while cpu_irq_req=0 is ignored.
- cpu_vector = VEC_BASE + active_id*VEC_STRIDE, truncated modulo 2^VEC_W. It is stable whenever cpu_irq_req=1.
- Latency:
  - irq_out rises in cycle N; cpu_irq_req=1 in cycle N+1.
  - ack coincides with taken.
  - After EOI in cycle M, the earliest next request is in cycle M+2 (IDLE in M+1).
- ack is a single-cycle pulse per service. It never asserts twice for one request.

Optional Feature:
- Macro: IC_SVC_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ and clears on entering REQ.
  - If TIMEOUT_CYCLES consecutive REQ cycles pass without taken, go to IDLE with no ack and set timeout_err=1 (sticky until reset).
  - The interrupt stays pending in the controller and is re-requested.
  - A return to IDLE on id mismatch also restarts the count.
- Undefined: no counter and no timeout_err port. REQ waits indefinitely.

Test Plan:
- Single service: irq_out=1, irq_id=3 → next cycle cpu_irq_req=1, cpu_vector=16'h010C. Taken → ack=1 for one cycle, busy=1. cpu_eoi → busy=0, svc_count=1.
- Preempted request: in REQ with active_id=5, irq_id changes to 1 before taken → cpu_irq_req drops the same cycle, no ack. Two cycles later cpu_irq_req=1 with cpu_vector=16'h0104.
- Back-to-back: pending ids 2 and 6. Service 2 to EOI → next request is id 6 with cpu_vector=16'h0118. svc_count=2 after the second EOI.
- Spurious inputs: cpu_eoi and cpu_irq_taken pulsed in IDLE and cpu_eoi pulsed in REQ → no ack, no state change, svc_count unchanged.
- Reset mid-service: assert rstn=0 while busy=1 → all outputs return to reset values asynchronously, and ack is never asserted.
- With IC_SVC_TIMEOUT_EN and TIMEOUT_CYCLES=8: hold irq_out=1, id 4, with no taken → after 8 REQ cycles req drops, timeout_err=1 and stays 1. The request reasserts, and a later taken produces a normal ack.
